yd_dbus_resp: RTL and testbench

Data-bus responder for the YD core's data space: it answers the core's `d_addr`/`d_din`/`d_we` requests and returns `d_dout` one cycle later. It holds the data RAM plus a small memory-mapped I/O window (GPIO and one timer with a compare flag). It sits directly on the core's dbus, parallel to the instruction memory on the ibus.

---
 rtl/yd_pkg.sv | 24 ++
 rtl/yd_dbus_resp_if.sv | 9 +
 rtl/yd_dtimer.sv | 55 +++++
 rtl/yd_dbus_resp.sv | 67 ++++++
 tb/tb_yd_dbus_resp.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/yd_pkg.sv
// yd_pkg: shared YD data-space constants (MMIO base, register offsets, TCTL bits)
package yd_pkg;
    localparam logic [7:0] MMIO_BASE = 8'hFF;
    localparam logic [7:0] GPO_OFS   = 8'h00;
    localparam logic [7:0] GPI_OFS   = 8'h01;
    localparam logic [7:0] TCNT_OFS  = 8'h02;
    localparam logic [7:0] TCMP_OFS  = 8'h03;
    localparam logic [7:0] TPRE_OFS  = 8'h04;
    localparam logic [7:0] TCTL_OFS  = 8'h05;
    localparam logic [7:0] TSTA_OFS  = 8'h06;
    localparam int TCTL_EN = 0;
    localparam int TCTL_IE = 1;
    typedef struct packed {
        logic [15:0] cnt;
        logic [15:0] cmp;
        logic [15:0] pre;
        logic        en;
        logic        ie;
        logic        flag;
    } tmr_regs_t;
    function automatic logic is_mmio(input logic [15:0] a);
        return a[15:8] == MMIO_BASE;
    endfunction
endpackage

// File: rtl/yd_dbus_resp_if.sv
// yd_dbus_resp_if: core data-bus request/response signals
interface yd_dbus_resp_if;
    logic [15:0] d_addr;
    logic [15:0] d_din;
    logic        d_we;
    logic [15:0] d_dout;
    modport master (output d_addr, d_din, d_we, input d_dout);
    modport slave  (input d_addr, d_din, d_we, output d_dout);
endinterface

// File: rtl/yd_dtimer.sv
// yd_dtimer: prescaled 16-bit timer with compare flag and registered irq
module yd_dtimer
    import yd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we_cnt,
    input  logic        we_cmp,
    input  logic        we_pre,
    input  logic        we_ctl,
    input  logic        we_sta,
    input  logic [15:0] wdata,
    output tmr_regs_t   regs,
    output logic        irq
);
    logic [15:0] pcnt;
    logic [15:0] inc;
    logic        tick;
    logic        hit;
    always_comb begin
        inc  = regs.cnt + 16'd1;
        tick = regs.en && pcnt == 16'd0;
        hit  = tick && !we_cnt && inc == regs.cmp;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '{cnt: 16'h0, cmp: 16'hFFFF, pre: 16'h0, en: 1'b0, ie: 1'b0, flag: 1'b0};
            pcnt <= 16'h0;
            irq  <= 1'b0;
        end else begin
            if (we_pre)
                pcnt <= wdata;
            else if (regs.en)
                pcnt <= tick ? regs.pre : pcnt - 16'd1;
            if (we_pre)
                regs.pre <= wdata;
            if (we_cmp)
                regs.cmp <= wdata;
            if (we_ctl) begin
                regs.en <= wdata[TCTL_EN];
                regs.ie <= wdata[TCTL_IE];
            end
            if (we_cnt)
                regs.cnt <= wdata;
            else if (tick)
                regs.cnt <= inc;
            // a compare hit outranks a simultaneous W1C
            if (hit)
                regs.flag <= 1'b1;
            else if (we_sta && wdata[0])
                regs.flag <= 1'b0;
            irq <= regs.flag & regs.ie;
        end
    end
endmodule

// File: rtl/yd_dbus_resp.sv
// yd_dbus_resp: data RAM plus GPIO/timer MMIO window on the core dbus, 1-cycle read
module yd_dbus_resp
    import yd_pkg::*;
#(
    parameter int          AW      = 10,
    parameter logic [15:0] GPO_RST = 16'h0000
) (
    input  logic           clk,
    input  logic           rst,
    yd_dbus_resp_if.slave  bus,
    input  logic [15:0]    gpi,
    output logic [15:0]    gpo,
    output logic           irq
);
    logic [15:0] ram [2**AW];
    logic [15:0] gpi_s1;
    logic [15:0] gpi_s2;
    logic [15:0] mmio_q;
    logic [7:0]  ofs;
    logic        mmio;
    logic        wr;
    logic        we_mmio;
    tmr_regs_t   tmr;
    always_comb begin
        mmio    = is_mmio(bus.d_addr);
        ofs     = bus.d_addr[7:0];
        wr      = bus.d_we && !rst;
        we_mmio = wr && mmio;
        mmio_q  = ofs == GPO_OFS  ? gpo :
                  ofs == GPI_OFS  ? gpi_s2 :
                  ofs == TCNT_OFS ? tmr.cnt :
                  ofs == TCMP_OFS ? tmr.cmp :
                  ofs == TPRE_OFS ? tmr.pre :
                  ofs == TCTL_OFS ? {14'h0, tmr.ie, tmr.en} :
                  ofs == TSTA_OFS ? {15'h0, tmr.flag} : 16'h0;
    end
    always_ff @(posedge clk)
        if (wr && !mmio)
            ram[bus.d_addr[AW-1:0]] <= bus.d_din;
    // register reads sample pre-edge state, giving read-first behaviour everywhere
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.d_dout <= 16'h0;
            gpo        <= GPO_RST;
            gpi_s1     <= 16'h0;
            gpi_s2     <= 16'h0;
        end else begin
            bus.d_dout <= mmio ? mmio_q : ram[bus.d_addr[AW-1:0]];
            gpi_s1     <= gpi;
            gpi_s2     <= gpi_s1;
            if (we_mmio && ofs == GPO_OFS)
                gpo <= bus.d_din;
        end
    end
    yd_dtimer u_tmr (
        .clk    (clk),
        .rst    (rst),
        .we_cnt (we_mmio && ofs == TCNT_OFS),
        .we_cmp (we_mmio && ofs == TCMP_OFS),
        .we_pre (we_mmio && ofs == TPRE_OFS),
        .we_ctl (we_mmio && ofs == TCTL_OFS),
        .we_sta (we_mmio && ofs == TSTA_OFS),
        .wdata  (bus.d_din),
        .regs   (tmr),
        .irq    (irq)
    );
endmodule

// File: tb/tb_yd_dbus_resp.sv
// tb_yd_dbus_resp: directed and randomized checks of yd_dbus_resp against a behavioural model
module tb_yd_dbus_resp;
    localparam int          AW      = 10;
    localparam logic [15:0] GPO_RST = 16'h5A0F;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] gpi;
    logic [15:0] gpo;
    logic        irq;
    int checks = 0;
    int passed = 0;
    yd_dbus_resp_if bus ();
    yd_dbus_resp #(.AW(AW), .GPO_RST(GPO_RST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .gpi (gpi),
        .gpo (gpo),
        .irq (irq)
    );
    always #5 clk = ~clk;
    // model state
    logic [15:0] mram [1024];
    bit          mknown [1024];
    logic [15:0] m_dout, m_gpo, m_s1, m_s2, m_cnt, m_cmp, m_pre, m_pcnt;
    bit          m_en, m_ie, m_flag, m_irq, m_dknown;
    function automatic logic [15:0] m_read(input logic [15:0] a, output bit known);
        known = 1'b1;
        if (a[15:8] != 8'hFF) begin
            known = mknown[a[AW-1:0]];
            return mram[a[AW-1:0]];
        end
        case (a[7:0])
            8'h00: return m_gpo;
            8'h01: return m_s2;
            8'h02: return m_cnt;
            8'h03: return m_cmp;
            8'h04: return m_pre;
            8'h05: return {14'h0, m_ie, m_en};
            8'h06: return {15'h0, m_flag};
            default: return 16'h0;
        endcase
    endfunction
    task automatic step(input logic [15:0] a, input logic [15:0] d, input bit w, input bit r = 1'b0);
        bit k, mm, tick, hit;
        logic [15:0] rv;
        bus.d_addr = a;
        bus.d_din  = d;
        bus.d_we   = w;
        rst        = r;
        rv = m_read(a, k);
        mm = a[15:8] == 8'hFF;
        if (r) begin
            m_dout = 0; m_dknown = 1; m_gpo = GPO_RST; m_s1 = 0; m_s2 = 0;
            m_cnt = 0; m_cmp = 16'hFFFF; m_pre = 0; m_pcnt = 0;
            m_en = 0; m_ie = 0; m_flag = 0; m_irq = 0;
        end else begin
            m_dout = rv; m_dknown = k;
            m_irq = m_flag & m_ie;
            m_s2 = m_s1; m_s1 = gpi;
            tick = m_en && m_pcnt == 0;
            hit = 0;
            if (tick) begin
                hit = !(w && mm && a[7:0] == 8'h02) && (m_cnt + 16'd1) == m_cmp;
                m_cnt = m_cnt + 16'd1;
            end
            if (m_en) m_pcnt = (m_pcnt == 0) ? m_pre : m_pcnt - 16'd1;
            if (w && !mm) begin
                mram[a[AW-1:0]] = d;
                mknown[a[AW-1:0]] = 1;
            end else if (w) begin
                case (a[7:0])
                    8'h00: m_gpo = d;
                    8'h02: m_cnt = d;
                    8'h03: m_cmp = d;
                    8'h04: begin m_pre = d; m_pcnt = d; end
                    8'h05: begin m_en = d[0]; m_ie = d[1]; end
                    8'h06: if (d[0]) m_flag = 0;
                    default: ;
                endcase
            end
            if (hit) m_flag = 1;
        end
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset;
        step(16'h0, 16'h0, 1'b0, 1'b1);
        step(16'hFF00, 16'h1111, 1'b1, 1'b1);
        checks++; if (bus.d_dout !== 16'h0) $display("FAIL reset_dout: got %h expected 0000", bus.d_dout); else passed++;
        checks++; if (gpo !== GPO_RST) $display("FAIL reset_gpo: got %h expected %h", gpo, GPO_RST); else passed++;
        checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq); else passed++;
        step(16'hFF03, 16'h0, 1'b0);
        checks++; if (bus.d_dout !== 16'hFFFF) $display("FAIL reset_tcmp: got %h expected FFFF", bus.d_dout); else passed++;
        step(16'hFF02, 16'h0, 1'b0);
        checks++; if (bus.d_dout !== 16'h0) $display("FAIL reset_tcnt: got %h expected 0000", bus.d_dout); else passed++;
    endtask
    task automatic test_ram;
        step(16'h0005, 16'h1234, 1'b1);
        step(16'h0005, 16'h0, 1'b0);
        checks++; if (bus.d_dout !== 16'h1234) $display("FAIL ram_read: got %h expected 1234", bus.d_dout); else passed++;
        step(16'h0405, 16'h0, 1'b0);
        checks++; if (bus.d_dout !== 16'h1234) $display("FAIL ram_alias: got %h expected 1234", bus.d_dout); else passed++;
    endtask
    task automatic test_read_first;
        step(16'h0010, 16'h0001, 1'b1);
        step(16'h0010, 16'hBEEF, 1'b1);
        checks++; if (bus.d_dout !== 16'h0001) $display("FAIL read_first_old: got %h expected 0001", bus.d_dout); else passed++;
        step(16'h0010, 16'h0, 1'b0);
        checks++; if (bus.d_dout !== 16'hBEEF) $display("FAIL read_first_new: got %h expected BEEF", bus.d_dout); else passed++;
    endtask
    task automatic test_gpio;
        step(16'hFF00, 16'hA5A5, 1'b1);
        checks++; if (gpo !== 16'hA5A5) $display("FAIL gpo_write: got %h expected A5A5", gpo); else passed++;
        gpi = 16'h00F0;
        step(16'h0005, 16'h0, 1'b0);
        step(16'h0005, 16'h0, 1'b0);
        step(16'hFF01, 16'h0, 1'b0);
        checks++; if (bus.d_dout !== 16'h00F0) $display("FAIL gpi_sync: got %h expected 00F0", bus.d_dout); else passed++;
    endtask
    task automatic test_timer;
        step(16'hFF04, 16'd2, 1'b1);
        step(16'hFF03, 16'd3, 1'b1);
        step(16'hFF05, 16'd3, 1'b1);
        // three increments at P+1=3 cycles each
        for (int i = 0; i < 9; i++) step(16'hFF02, 16'h0, 1'b0);
        checks++; if (irq !== 1'b0) $display("FAIL tmr_irq_early: got %b expected 0", irq); else passed++;
        step(16'hFF06, 16'h0, 1'b0);
        checks++; if (bus.d_dout !== 16'h0001) $display("FAIL tmr_flag: got %h expected 0001", bus.d_dout); else passed++;
        checks++; if (irq !== 1'b1) $display("FAIL tmr_irq: got %b expected 1", irq); else passed++;
        step(16'hFF02, 16'h0, 1'b0);
        checks++; if (bus.d_dout !== 16'd3) $display("FAIL tmr_tcnt: got %h expected 0003", bus.d_dout); else passed++;
        step(16'hFF06, 16'h1, 1'b1);
        step(16'hFF06, 16'h0, 1'b0);
        checks++; if (bus.d_dout !== 16'h0) $display("FAIL tmr_w1c: got %h expected 0000", bus.d_dout); else passed++;
        checks++; if (irq !== 1'b0) $display("FAIL tmr_irq_clr: got %b expected 0", irq); else passed++;
    endtask
    task automatic test_collisions;
        step(16'hFF05, 16'h0, 1'b1);
        step(16'hFF04, 16'h0, 1'b1);
        step(16'hFF02, 16'd4, 1'b1);
        step(16'hFF03, 16'd5, 1'b1);
        step(16'hFF06, 16'h1, 1'b1);
        step(16'hFF05, 16'h1, 1'b1);
        step(16'hFF06, 16'h1, 1'b1);
        step(16'hFF06, 16'h0, 1'b0);
        checks++; if (bus.d_dout !== 16'h0001) $display("FAIL set_beats_w1c: got %h expected 0001", bus.d_dout); else passed++;
        step(16'hFF02, 16'h0100, 1'b1);
        step(16'hFF02, 16'h0, 1'b0);
        checks++; if (bus.d_dout !== 16'h0100) $display("FAIL write_beats_inc: got %h expected 0100", bus.d_dout); else passed++;
        step(16'hFF05, 16'h0, 1'b1);
        step(16'hFF02, 16'hFFFF, 1'b1);
        step(16'hFF05, 16'h1, 1'b1);
        step(16'hFF05, 16'h0, 1'b1);
        step(16'hFF02, 16'h0, 1'b0);
        checks++; if (bus.d_dout !== 16'h0) $display("FAIL tcnt_wrap: got %h expected 0000", bus.d_dout); else passed++;
        step(16'hFF06, 16'h1, 1'b1);
    endtask
    task automatic test_random;
        logic [15:0] a, d;
        bit w;
        for (int i = 0; i < 300; i++) begin
            a = $urandom_range(0, 1) ? {8'hFF, 8'($urandom_range(0, 8))}
                                     : (16'($urandom_range(0, 15)) | ($urandom_range(0, 1) ? 16'h0400 : 16'h0));
            d = 16'($urandom);
            if (a == 16'hFF04) d = d & 16'h0003;
            w = $urandom_range(0, 2) == 0;
            gpi = 16'($urandom);
            step(a, d, w);
            if (m_dknown) begin
                checks++; if (bus.d_dout !== m_dout) $display("FAIL rand_dout[%0d] addr %h: got %h expected %h", i, a, bus.d_dout, m_dout); else passed++;
            end
            checks++; if (gpo !== m_gpo) $display("FAIL rand_gpo[%0d]: got %h expected %h", i, gpo, m_gpo); else passed++;
            checks++; if (irq !== m_irq) $display("FAIL rand_irq[%0d]: got %b expected %b", i, irq, m_irq); else passed++;
        end
    endtask
    task automatic test_reset_mid;
        step(16'hFF04, 16'h0, 1'b1);
        step(16'hFF05, 16'h3, 1'b1);
        step(16'hFF00, 16'hA5A5, 1'b1);
        step(16'h0020, 16'hCAFE, 1'b1);
        checks++; if (gpo !== 16'hA5A5) $display("FAIL mid_gpo_pre: got %h expected A5A5", gpo); else passed++;
        step(16'hFF00, 16'h1111, 1'b1, 1'b1);
        checks++; if (gpo !== GPO_RST) $display("FAIL mid_gpo_rst: got %h expected %h", gpo, GPO_RST); else passed++;
        checks++; if (bus.d_dout !== 16'h0) $display("FAIL mid_dout_rst: got %h expected 0000", bus.d_dout); else passed++;
        step(16'hFF02, 16'h0, 1'b0);
        checks++; if (bus.d_dout !== 16'h0) $display("FAIL mid_tcnt: got %h expected 0000", bus.d_dout); else passed++;
        step(16'h0020, 16'h0, 1'b0);
        checks++; if (bus.d_dout !== 16'hCAFE) $display("FAIL mid_ram_kept: got %h expected CAFE", bus.d_dout); else passed++;
        step(16'hFF00, 16'h0, 1'b0);
        checks++; if (bus.d_dout !== GPO_RST) $display("FAIL mid_write_ignored: got %h expected %h", bus.d_dout, GPO_RST); else passed++;
    endtask
    initial begin
        rst = 1'b1;
        gpi = 16'h0;
        bus.d_addr = 16'h0;
        bus.d_din  = 16'h0;
        bus.d_we   = 1'b0;
        for (int i = 0; i < 1024; i++) mknown[i] = 1'b0;
        test_reset;
        test_ram;
        test_read_first;
        test_gpio;
        test_timer;
        test_collisions;
        test_random;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
